// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the DLX pipeline: run-mode control, load-use
// hazard bubbles, HALT drain sequencing and cycle/stall counters.
module pipeline_run_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step_req,
    input  logic             i_halt_instr,
    input  logic             i_idex_memRead,
    input  logic [4:0]       i_idex_rt,
    input  logic [4:0]       i_ifid_rs,
    input  logic [4:0]       i_ifid_rt,
    output logic             o_step,
    output logic             o_stall,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_halted,
    output logic             o_busy,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_stall_count
);

    // state     | meaning
    // IDLE      | waiting for i_start, pipeline frozen
    // RUN       | continuous execution
    // STEP_WAIT | single-step mode, frozen until i_step_req
    // STEP_EXEC | single advancing cycle in step mode
    // DRAIN     | HALT decoded, retiring in-flight instructions
    // HALTED    | program finished, sticky until reset
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP_WAIT = 3'd2,
        S_STEP_EXEC = 3'd3,
        S_DRAIN     = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [DW-1:0]    r_drain_cnt;
    logic             w_drain_load;
    logic             w_adv;
    logic             w_haz;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_stall_count;

    assign w_adv = (r_state == S_RUN) || (r_state == S_STEP_EXEC) || (r_state == S_DRAIN);
    assign w_haz = i_idex_memRead && (i_idex_rt != 5'd0) &&
                   ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

    // o_step depends on the state register only
    assign o_step        = !w_adv;
    assign o_stall       = w_adv && w_haz && ((r_state == S_RUN) || (r_state == S_STEP_EXEC));
    assign o_pc_write    = w_adv && !o_stall && (r_state != S_DRAIN);
    assign o_ifid_write  = o_pc_write;
    assign o_halted      = (r_state == S_HALTED);
    assign o_busy        = w_adv || (r_state == S_STEP_WAIT);
    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;
    assign o_stall_count = r_stall_count;

    always_comb begin
        w_next       = r_state;
        w_drain_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = i_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
                if (i_halt_instr && !o_stall) begin
                    w_next       = S_DRAIN;
                    w_drain_load = 1'b1;
                end
            end
            S_STEP_WAIT: begin
                if (i_step_req) w_next = S_STEP_EXEC;
            end
            S_STEP_EXEC: begin
                // a stalled HALT stays in IF/ID and is seen again next step
                if (i_halt_instr && !o_stall) begin
                    w_next       = S_DRAIN;
                    w_drain_load = 1'b1;
                end else begin
                    w_next = S_STEP_WAIT;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) w_next = S_HALTED;
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_drain_cnt   <= '0;
            r_cycle_count <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_drain_load)
                r_drain_cnt <= DRAIN_LOAD;
            else if ((r_state == S_DRAIN) && (r_drain_cnt != '0))
                r_drain_cnt <= r_drain_cnt - DW'(1);
            if (w_adv)
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (o_stall)
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios plus random stimulus, all
// cycles checked against a cycle-level behavioural model.
module tb_pipeline_run_ctrl;

    localparam int DRAIN_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, mode = 1'b0, step_req = 1'b0;
    logic        halt = 1'b0, memrd = 1'b0;
    logic [4:0]  idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
    logic        o_step, o_stall, o_pc_write, o_ifid_write, o_halted, o_busy;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count, o_stall_count;

    int n_vec = 0;
    int n_err = 0;

    // model: state number as listed in the encoding, drain cycles remaining, counters
    int          m_state = 0;
    int          m_drain_left = 0;
    logic [31:0] m_cycles = '0, m_stalls = '0;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(32)) dut (
        .clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
        .i_step_req(step_req), .i_halt_instr(halt), .i_idex_memRead(memrd),
        .i_idex_rt(idex_rt), .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
        .o_step(o_step), .o_stall(o_stall), .o_pc_write(o_pc_write),
        .o_ifid_write(o_ifid_write), .o_halted(o_halted), .o_busy(o_busy),
        .o_state(o_state), .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs applied; returns after the next negedge.
    task automatic tick();
        bit e_adv, e_haz, e_stall, e_pcw;
        #1;
        e_adv   = (m_state == 1) || (m_state == 3) || (m_state == 4);
        e_haz   = memrd && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        e_stall = e_adv && e_haz && ((m_state == 1) || (m_state == 3));
        e_pcw   = e_adv && !e_stall && (m_state != 4);
        if (m_valid) begin
            chk("state",  32'(o_state),      32'(m_state));
            chk("step",   32'(o_step),       32'(!e_adv));
            chk("stall",  32'(o_stall),      32'(e_stall));
            chk("pc_wr",  32'(o_pc_write),   32'(e_pcw));
            chk("ifid_wr",32'(o_ifid_write), 32'(e_pcw));
            chk("halted", 32'(o_halted),     32'(m_state == 5));
            chk("busy",   32'(o_busy),       32'(m_state >= 1 && m_state <= 4));
            chk("cycles", o_cycle_count,     m_cycles);
            chk("stalls", o_stall_count,     m_stalls);
        end
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_drain_left = 0; m_cycles = '0; m_stalls = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (e_adv)   m_cycles = m_cycles + 1;
            if (e_stall) m_stalls = m_stalls + 1;
            case (m_state)
                0: if (start) m_state = mode ? 2 : 1;
                1: if (halt && !e_stall) begin m_state = 4; m_drain_left = DRAIN_CYCLES; end
                2: if (step_req) m_state = 3;
                3: if (halt && !e_stall) begin m_state = 4; m_drain_left = DRAIN_CYCLES; end
                   else m_state = 2;
                4: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_state = 5;
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 0; start = 0; mode = 0; step_req = 0; halt = 0; memrd = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    endtask

    task automatic do_reset();
        quiet(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        tick();
        chk("rst_state", 32'(o_state), 0);
        chk("rst_step",  32'(o_step), 1);

        // continuous run, 10 advancing cycles
        start = 1; mode = 0; tick(); start = 0;
        repeat (10) tick();
        chk("run_cyc10", o_cycle_count, 10);
        chk("run_stl0",  o_stall_count, 0);

        // load-use hazard, then the same with rt=0
        memrd = 1; idex_rt = 5; ifid_rs = 5; tick();
        chk("haz_cnt", o_stall_count, 1);
        idex_rt = 0; ifid_rs = 0; tick();
        chk("haz_rt0", o_stall_count, 1);
        quiet();

        // HALT coincident with a hazard, then accepted, drain, halted
        halt = 1; memrd = 1; idex_rt = 7; ifid_rt = 7; tick();
        memrd = 0; tick();
        halt = 0;
        repeat (DRAIN_CYCLES) tick();
        chk("halted", 32'(o_halted), 1);
        start = 1; tick(); start = 0;
        chk("halt_sticky", 32'(o_state), 5);

        // single-step mode
        do_reset();
        start = 1; mode = 1; tick(); start = 0; mode = 0;
        repeat (20) tick();
        for (int i = 0; i < 3; i++) begin
            step_req = 1; tick();
            tick();              // request during STEP_EXEC is ignored
            step_req = 0; tick();
        end
        chk("step_cyc3", o_cycle_count, 3);

        // reset on the 2nd DRAIN cycle
        do_reset();
        start = 1; tick(); start = 0; tick();
        halt = 1; tick(); halt = 0;
        tick();
        reset = 1; tick(); reset = 0;
        chk("drst_state", 32'(o_state), 0);
        chk("drst_cyc",   o_cycle_count, 0);
        chk("drst_halt",  32'(o_halted), 0);
        chk("drst_step",  32'(o_step), 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(199) == 0);
            start    = ($urandom_range(19) == 0);
            mode     = $urandom_range(1);
            step_req = ($urandom_range(3) == 0);
            halt     = ($urandom_range(29) == 0);
            memrd    = ($urandom_range(2) == 0);
            idex_rt  = 5'($urandom_range(3));
            ifid_rs  = 5'($urandom_range(3));
            ifid_rt  = 5'($urandom_range(3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
